// File: rtl/food_spawn_ctrl.sv
// Food placement controller for an 8x8 snake board: picks a pseudo-random free
// cell, falls back to a row-major sweep, and tracks eating and score.
module food_spawn_ctrl (
    input  logic       clk_food,
    input  logic       reset,
    input  logic [7:0] row_1,
    input  logic [7:0] row_2,
    input  logic [7:0] row_3,
    input  logic [7:0] row_4,
    input  logic [7:0] row_5,
    input  logic [7:0] row_6,
    input  logic [7:0] row_7,
    input  logic [7:0] row_8,
    input  logic [2:0] head_x,
    input  logic [2:0] head_y,
    input  logic       start,
    output logic [2:0] food_x,
    output logic [2:0] food_y,
    output logic       food_valid,
    output logic       food_collide,
    output logic       spawn_busy,
    output logic       board_full,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        SCAN,
        PLACED,
        FULL
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  lfsr;
    logic [2:0]  try_cnt;
    logic [2:0]  try_next;
    logic [5:0]  scan_idx;
    logic [5:0]  idx_next;
    logic [2:0]  food_x_next;
    logic [2:0]  food_y_next;
    logic        collide_next;
    logic [7:0]  score_next;

    logic [63:0] occ;
    logic [2:0]  cand_x;
    logic [2:0]  cand_y;
    logic        cand_free;
    logic        head_hit;

    // Occupancy is flattened so that cell (x,y) sits at bit index {y,x}.
    assign occ = {row_8, row_7, row_6, row_5, row_4, row_3, row_2, row_1};

    always_comb begin
        cand_x = lfsr[2:0];
        cand_y = lfsr[5:3];
        if (state == SCAN) begin
            cand_x = scan_idx[2:0];
            cand_y = scan_idx[5:3];
        end
    end

    assign cand_free = !occ[{cand_y, cand_x}] && !((cand_x == head_x) && (cand_y == head_y));
    assign head_hit  = (head_x == food_x) && (head_y == food_y);

    always_comb begin
        state_next   = state;
        try_next     = try_cnt;
        idx_next     = scan_idx;
        food_x_next  = food_x;
        food_y_next  = food_y;
        collide_next = 1'b0;
        score_next   = score;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SPAWN;
                    try_next   = 3'd0;
                end
            end
            SPAWN: begin
                if (cand_free) begin
                    food_x_next = cand_x;
                    food_y_next = cand_y;
                    state_next  = PLACED;
                end else if (try_cnt == 3'd7) begin
                    state_next = SCAN;
                    idx_next   = 6'd0;
                end else begin
                    try_next = try_cnt + 3'd1;
                end
            end
            SCAN: begin
                if (cand_free) begin
                    food_x_next = cand_x;
                    food_y_next = cand_y;
                    state_next  = PLACED;
                end else if (scan_idx == 6'd63) begin
                    state_next = FULL;
                end else begin
                    idx_next = scan_idx + 6'd1;
                end
            end
            PLACED: begin
                if (head_hit) begin
                    state_next   = SPAWN;
                    try_next     = 3'd0;
                    collide_next = 1'b1;
                    score_next   = score + 8'd1;
                end
            end
            FULL: state_next = FULL;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge clk_food) begin
        if (reset) begin
            state        <= IDLE;
            lfsr         <= 8'hA5;
            try_cnt      <= 3'd0;
            scan_idx     <= 6'd0;
            food_x       <= 3'd0;
            food_y       <= 3'd0;
            food_valid   <= 1'b0;
            food_collide <= 1'b0;
            spawn_busy   <= 1'b0;
            board_full   <= 1'b0;
            score        <= 8'd0;
        end else begin
            state        <= state_next;
            lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            try_cnt      <= try_next;
            scan_idx     <= idx_next;
            food_x       <= food_x_next;
            food_y       <= food_y_next;
            food_valid   <= (state_next == PLACED);
            food_collide <= collide_next;
            spawn_busy   <= (state_next == SPAWN) || (state_next == SCAN);
            board_full   <= (state_next == FULL);
            score        <= score_next;
        end
    end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Scoreboard bench for food_spawn_ctrl: stimulus predicts placements from a
// board-level reference model, a negedge monitor pops and compares events.
module tb_food_spawn_ctrl;

    localparam int EV_PLACE   = 0;
    localparam int EV_COLLIDE = 1;
    localparam int EV_FULL    = 2;

    typedef struct {
        int         kind;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] score;
        int         cyc;
    } exp_t;

    logic       clk_food = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] board [8];
    logic [2:0] head_x   = 3'd0;
    logic [2:0] head_y   = 3'd0;
    logic       start    = 1'b0;
    logic [7:0] row_1, row_2, row_3, row_4, row_5, row_6, row_7, row_8;
    logic [2:0] food_x, food_y;
    logic       food_valid, food_collide, spawn_busy, board_full;
    logic [7:0] score;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    exp_t       exp_q [$];
    logic [7:0] model_lfsr;
    logic [7:0] score_model = 8'd0;
    logic [2:0] last_x = 3'd0;
    logic [2:0] last_y = 3'd0;
    logic       prev_valid = 1'b0;
    logic       prev_full  = 1'b0;

    assign row_1 = board[0];
    assign row_2 = board[1];
    assign row_3 = board[2];
    assign row_4 = board[3];
    assign row_5 = board[4];
    assign row_6 = board[5];
    assign row_7 = board[6];
    assign row_8 = board[7];

    food_spawn_ctrl dut (
        .clk_food(clk_food), .reset(reset),
        .row_1(row_1), .row_2(row_2), .row_3(row_3), .row_4(row_4),
        .row_5(row_5), .row_6(row_6), .row_7(row_7), .row_8(row_8),
        .head_x(head_x), .head_y(head_y), .start(start),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .food_collide(food_collide), .spawn_busy(spawn_busy),
        .board_full(board_full), .score(score)
    );

    always #5 clk_food = ~clk_food;

    always @(posedge clk_food) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Free-running reference LFSR tracking the one in the design cycle by cycle.
    always @(posedge clk_food) begin
        if (reset) model_lfsr <= 8'hA5;
        else       model_lfsr <= lfsr_step(model_lfsr);
    end

    function automatic logic cell_free(input int x, input int y);
        return (board[y][x] == 1'b0) && !((x == int'(head_x)) && (y == int'(head_y)));
    endfunction

    function automatic exp_t predict_spawn(input int base);
        exp_t       e;
        logic [7:0] l;
        l       = model_lfsr;
        e.score = score_model;
        for (int t = 0; t < 8; t++) begin
            if (cell_free(int'(l[2:0]), int'(l[5:3]))) begin
                e.kind = EV_PLACE;
                e.x    = l[2:0];
                e.y    = l[5:3];
                e.cyc  = base + t + 1;
                return e;
            end
            l = lfsr_step(l);
        end
        for (int i = 0; i < 64; i++) begin
            if (cell_free(i % 8, i / 8)) begin
                e.kind = EV_PLACE;
                e.x    = 3'(i % 8);
                e.y    = 3'(i / 8);
                e.cyc  = base + 9 + i;
                return e;
            end
        end
        e.kind = EV_FULL;
        e.x    = 3'd0;
        e.y    = 3'd0;
        e.cyc  = base + 72;
        return e;
    endfunction

    task automatic check_val(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        logic ok;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc);
        if (kind == EV_PLACE)   ok = ok && (food_x == e.x) && (food_y == e.y);
        if (kind == EV_COLLIDE) ok = ok && (score == e.score) && !food_valid;
        if (kind == EV_FULL)    ok = ok && !food_valid && !spawn_busy;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL event: got kind %0d cyc %0d food (%0d,%0d) score %0d valid %0b, required kind %0d cyc %0d food (%0d,%0d) score %0d",
                     kind, cyc, food_x, food_y, score, food_valid, e.kind, e.cyc, e.x, e.y, e.score);
        end
    endtask

    // Monitor: any placement, eat pulse or full indication must match the queue head.
    always @(negedge clk_food) begin
        if (!reset) begin
            if (food_valid && !prev_valid) check_event(EV_PLACE);
            if (food_collide)              check_event(EV_COLLIDE);
            if (board_full && !prev_full)  check_event(EV_FULL);
        end
        prev_valid = food_valid;
        prev_full  = board_full;
    end

    task automatic wait_drain(input int limit);
        for (int n = 0; n < limit && exp_q.size() != 0; n++) @(negedge clk_food);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: %0d events still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk_food);
        exp_q.delete();
        score_model = 8'd0;
        check_val("rst_food_x", int'(food_x), 0);
        check_val("rst_food_y", int'(food_y), 0);
        check_val("rst_food_valid", int'(food_valid), 0);
        check_val("rst_food_collide", int'(food_collide), 0);
        check_val("rst_spawn_busy", int'(spawn_busy), 0);
        check_val("rst_board_full", int'(board_full), 0);
        check_val("rst_score", int'(score), 0);
        reset = 1'b0;
    endtask

    task automatic apply_start();
        exp_t e;
        start = 1'b1;
        @(negedge clk_food);
        start = 1'b0;
        e = predict_spawn(cyc);
        exp_q.push_back(e);
        last_x = e.x;
        last_y = e.y;
    endtask

    task automatic fill_board(input logic [7:0] v);
        for (int r = 0; r < 8; r++) board[r] = v;
    endtask

    // Eat the current food while presenting a fresh random board for the respawn.
    task automatic eat_round();
        exp_t e;
        int   mode, fx, fy;
        mode = $urandom_range(0, 2);
        for (int r = 0; r < 8; r++) begin
            case (mode)
                0:       board[r] = 8'($urandom & $urandom);
                1:       board[r] = 8'($urandom);
                default: board[r] = 8'hFF;
            endcase
        end
        do begin
            fx = $urandom_range(0, 7);
            fy = $urandom_range(0, 7);
        end while (fx == int'(last_x) && fy == int'(last_y));
        board[fy][fx] = 1'b0;
        head_x = last_x;
        head_y = last_y;
        e.kind  = EV_COLLIDE;
        e.x     = last_x;
        e.y     = last_y;
        e.score = score_model + 8'd1;
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
        score_model = score_model + 8'd1;
        @(negedge clk_food);
        e = predict_spawn(cyc);
        exp_q.push_back(e);
        last_x = e.x;
        last_y = e.y;
        wait_drain(80);
    endtask

    initial begin
        int bad;
        int busy;
        fill_board(8'h00);
        repeat (2) @(negedge clk_food);

        // Reset values, then IDLE must hold with start low.
        do_reset();
        bad = 0;
        repeat (20) begin
            @(negedge clk_food);
            if (spawn_busy || food_valid || board_full) bad++;
        end
        check_val("idle_hold", bad, 0);

        // Empty board, head at origin.
        apply_start();
        wait_drain(12);
        check_val("empty_valid", int'(food_valid), 1);
        check_val("empty_not_head", int'(food_x != 3'd0 || food_y != 3'd0), 1);

        // Only (5,3) free: food must land there, then random eat/respawn rounds.
        do_reset();
        fill_board(8'hFF);
        board[3] = 8'hDF;
        head_x = 3'd0;
        head_y = 3'd0;
        apply_start();
        wait_drain(80);
        check_val("cell53_x", int'(food_x), 5);
        check_val("cell53_y", int'(food_y), 3);
        for (int k = 0; k < 10; k++) eat_round();
        check_val("score_after_rounds", int'(score), 10);

        // Single free cell at (7,7).
        do_reset();
        fill_board(8'hFF);
        board[7] = 8'h7F;
        head_x = 3'd0;
        head_y = 3'd0;
        apply_start();
        wait_drain(80);
        check_val("single_x", int'(food_x), 7);
        check_val("single_y", int'(food_y), 7);

        // Full board: 72 busy cycles, then terminal FULL.
        do_reset();
        fill_board(8'hFF);
        apply_start();
        busy = 0;
        bad  = 0;
        for (int n = 0; n < 100; n++) begin
            if (board_full) break;
            if (spawn_busy) busy++;
            if (food_valid) bad++;
            @(negedge clk_food);
        end
        wait_drain(5);
        check_val("full_busy_cycles", busy, 72);
        check_val("full_no_valid", bad, 0);
        start = 1'b1;
        repeat (5) @(negedge clk_food);
        start = 1'b0;
        check_val("full_terminal", int'(board_full), 1);

        // Reset in the middle of the sweep.
        do_reset();
        apply_start();
        repeat (40) @(negedge clk_food);
        do_reset();
        bad = 0;
        repeat (60) begin
            @(negedge clk_food);
            if (board_full || spawn_busy) bad++;
        end
        check_val("midreset_no_full", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/food_spawn_ctrl.md
FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 SHALL have a single clock domain on clk_food; reset is synchronous and active-high.
REQ-002 SHALL have port clk_food, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have ports row_1..row_8, input, 8 bits each: snake body occupancy bitmap. row_(y+1)[x]=1 means cell (x,y) is occupied.
REQ-005 SHALL have ports head_x and head_y, input, 3 bits each: snake head position.
REQ-006 SHALL have port start, input, 1 bit: game-start request, sampled only in IDLE.
REQ-007 SHALL have ports food_x and food_y, output, 3 bits each: registered food position.
REQ-008 SHALL have port food_valid, output, 1 bit: food is placed on the board.
REQ-009 SHALL have port food_collide, output, 1 bit: single-cycle pulse when the head eats the food.
REQ-010 SHALL have port spawn_busy, output, 1 bit: high in SPAWN and SCAN.
REQ-011 SHALL have port board_full, output, 1 bit: no free cell was found.
REQ-012 SHALL have port score, output, 8 bits: count of foods eaten, wrapping modulo 256.

Function
REQ-013 SHALL implement a five-state FSM with states IDLE, SPAWN, SCAN, PLACED and FULL.
REQ-014 SHALL include an 8-bit Fibonacci LFSR.
- Polynomial: x^8+x^6+x^5+x^4+1.
- Seed: 8'hA5 on reset.
- Advances every cycle in all states.
REQ-015 SHALL treat cell (x,y) as free iff row_(y+1)[x]=0 and (x,y) != (head_x,head_y), with inputs evaluated in the same cycle.
REQ-016 SHALL move from IDLE to SPAWN on the edge where start=1, and SHALL clear the try counter on that move.
REQ-017 SHALL, in SPAWN, test one candidate per cycle, with x=lfsr[2:0] and y=lfsr[5:3].
- Candidate free: register it into food_x/food_y, set food_valid=1 and go to PLACED on the same edge.
- Candidate occupied: increment the 3-bit try counter.
REQ-018 SHALL go from SPAWN to SCAN after the 8th consecutive occupied candidate, and SHALL clear the 6-bit scan index on that move.
REQ-019 SHALL, in SCAN, test the cell at index i (x=i[2:0], y=i[5:3]) once per cycle, in row-major order starting at 0.
- Cell free: place the food at that cell and go to PLACED.
- i=63 occupied: go to FULL.
- Otherwise: increment i.
REQ-020 SHALL, in PLACED, detect (head_x,head_y)==(food_x,food_y) on a clock edge. On the next cycle:
- food_collide=1 for exactly one cycle;
- food_valid=0;
- score increments;
- state is SPAWN, with the try counter cleared.
REQ-021 SHALL hold food_x/food_y at their last value while food_valid=0.
REQ-022 SHALL treat FULL as terminal: board_full=1, food_valid=0, spawn_busy=0, and exit only via reset.
REQ-023 SHALL ignore start in every state other than IDLE.
REQ-024 SHALL have all outputs registered, with no combinational input-to-output path.
REQ-025 SHALL have a worst-case latency from SPAWN entry to PLACED or FULL of 72 cycles: 8 SPAWN cycles plus 64 SCAN cycles.

Reset
REQ-026 SHALL, on reset=1 at any edge and in any state (including mid-SPAWN or mid-SCAN), set:
- state IDLE;
- LFSR 8'hA5;
- try counter 0 and scan index 0;
- food_x=0, food_y=0;
- food_valid=0, food_collide=0, spawn_busy=0, board_full=0;
- score=0.
REQ-027 SHALL give reset priority over start and over collision detection in the same cycle.

Verification
REQ-028 SHALL pass the reset scenario: assert reset for 1 cycle → next cycle shows all outputs 0 and spawn_busy=0, with start=0 holding IDLE indefinitely.
REQ-029 SHALL pass the empty-board scenario: all rows 8'h00, head (0,0), pulse start → food_valid=1 within 9 cycles, with (food_x,food_y) != (0,0) and matching a bit-exact LFSR reference model.
REQ-030 SHALL pass the single-free-cell scenario: rows 1-7 = 8'hFF, row_8 = 8'h7F, head (0,0), pulse start → food_valid=1 with food (7,7) within 73 cycles.
REQ-031 SHALL pass the full-board scenario: all rows 8'hFF, start at cycle N → spawn_busy=1 for cycles N+1..N+72, then board_full=1 from N+73, with food_valid staying 0.
REQ-032 SHALL pass the eat scenario: food placed at (5,3), drive head to (5,3) → food_collide=1 for exactly one cycle, score 0→1, food_valid=0, then respawn to a free cell.
REQ-033 SHALL pass the reset-mid-operation scenario: full board, assert reset at cycle N+40 (in SCAN) → next cycle in IDLE with all outputs at reset values, and board_full never asserts.
